// File: rtl/ms_timer_sched_pkg.sv
// ms_timer_sched_pkg: shared types, defaults and index-width helper for the ms timer scheduler
package ms_timer_sched_pkg;
    typedef enum logic {IDLE, SWEEP} sched_state_t;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W = 16;
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/ms_timer_chan_regs.sv
// ms_timer_chan_regs: per-channel countdown/active registers with start > cancel > service priority
module ms_timer_chan_regs
    import ms_timer_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int IW = idx_w(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       i_start,
    input  logic [NUM_CH-1:0]       i_cancel,
    input  logic [NUM_CH*CNT_W-1:0] i_dur,
    input  logic [IW-1:0]           i_idx,
    input  logic                    i_dec_en,
    output logic [NUM_CH-1:0]       o_active,
    output logic                    o_exp_stb,
    output logic [IW-1:0]           o_exp_idx,
    output logic [NUM_CH-1:0]       o_zero_exp
);
    logic [CNT_W-1:0]  r_count [NUM_CH];
    logic [NUM_CH-1:0] r_active;
    logic              r_exp_stb;
    logic [IW-1:0]     r_exp_idx;
    logic [NUM_CH-1:0] r_zero_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) r_count[i] <= '0;
            r_active   <= '0;
            r_exp_stb  <= 1'b0;
            r_exp_idx  <= '0;
            r_zero_exp <= '0;
        end else begin
            r_exp_stb  <= 1'b0;
            r_exp_idx  <= i_idx;
            r_zero_exp <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (i_start[i]) begin
                    // a zero duration expires immediately instead of arming
                    r_count[i]    <= i_dur[i*CNT_W +: CNT_W];
                    r_active[i]   <= |i_dur[i*CNT_W +: CNT_W];
                    r_zero_exp[i] <= ~|i_dur[i*CNT_W +: CNT_W];
                end else if (i_cancel[i]) begin
                    r_active[i] <= 1'b0;
                end else if (i_dec_en && i_idx == IW'(i) && r_active[i]) begin
                    if (r_count[i] == CNT_W'(1)) begin
                        r_count[i]  <= '0;
                        r_active[i] <= 1'b0;
                        r_exp_stb   <= 1'b1;
                    end else begin
                        r_count[i] <= r_count[i] - CNT_W'(1);
                    end
                end
            end
        end
    end

    assign o_active   = r_active;
    assign o_exp_stb  = r_exp_stb;
    assign o_exp_idx  = r_exp_idx;
    assign o_zero_exp = r_zero_exp;
endmodule

// File: rtl/ms_timer_scheduler.sv
// ms_timer_scheduler: multi-channel ms timeout service sharing one decrement unit swept on each 1 ms tick
module ms_timer_scheduler
    import ms_timer_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_1ms,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       cancel,
    input  logic [NUM_CH*CNT_W-1:0] dur_ms,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       expired,
    output logic                    sweeping,
    output logic                    overrun
);
    localparam int IW = idx_w(NUM_CH);

    sched_state_t      r_state;
    logic [IW-1:0]     r_idx;
    logic              r_pend;
    logic              r_ovr;
    logic              w_exp_stb;
    logic [IW-1:0]     w_exp_idx;
    logic [NUM_CH-1:0] w_zero_exp;
    logic [NUM_CH-1:0] w_exp_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_pend  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (tick_1ms && r_pend) r_ovr <= 1'b1;
            case (r_state)
                IDLE: if (tick_1ms || r_pend) begin
                    r_state <= SWEEP;
                    r_idx   <= '0;
                    r_pend  <= 1'b0;
                end
                SWEEP: if (r_idx == IW'(NUM_CH - 1)) begin
                    // a pending tick restarts the sweep back-to-back; a fresh one becomes pending
                    r_state <= r_pend ? SWEEP : IDLE;
                    r_idx   <= '0;
                    r_pend  <= tick_1ms;
                end else begin
                    r_idx <= r_idx + IW'(1);
                    if (tick_1ms) r_pend <= 1'b1;
                end
            endcase
        end
    end

    ms_timer_chan_regs #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IW(IW)) u_regs (
        .clk       (clk),
        .rst       (rst),
        .i_start   (start),
        .i_cancel  (cancel),
        .i_dur     (dur_ms),
        .i_idx     (r_idx),
        .i_dec_en  (r_state == SWEEP),
        .o_active  (busy),
        .o_exp_stb (w_exp_stb),
        .o_exp_idx (w_exp_idx),
        .o_zero_exp(w_zero_exp)
    );

    always_comb begin
        w_exp_dec = '0;
        if (w_exp_stb) w_exp_dec[w_exp_idx] = 1'b1;
    end

    assign expired  = w_exp_dec | w_zero_exp;
    assign sweeping = (r_state == SWEEP);
    assign overrun  = r_ovr;
endmodule

// File: tb/tb_ms_timer_scheduler.sv
// tb_ms_timer_scheduler: directed stimulus with a per-cycle reference model and literal checkpoints
module tb_ms_timer_scheduler;
    localparam int NUM_CH = 4;
    localparam int CNT_W = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    tick_1ms = 1'b0;
    logic [NUM_CH-1:0]       start = '0;
    logic [NUM_CH-1:0]       cancel = '0;
    logic [NUM_CH*CNT_W-1:0] dur_ms = '0;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       expired;
    logic                    sweeping;
    logic                    overrun;

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;
    logic [NUM_CH-1:0] seen = '0;

    int m_cnt [NUM_CH];
    bit [NUM_CH-1:0] m_act = '0;
    bit [NUM_CH-1:0] m_exp = '0;
    int m_pos = -1;
    bit m_pend = 1'b0;
    bit m_ovr = 1'b0;

    always #5 clk = ~clk;

    ms_timer_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_1ms(tick_1ms),
        .start   (start),
        .cancel  (cancel),
        .dur_ms  (dur_ms),
        .busy    (busy),
        .expired (expired),
        .sweeping(sweeping),
        .overrun (overrun)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // m_pos is the channel the sweep visits in the current cycle, -1 when no sweep runs
    task automatic model_step();
        bit [NUM_CH-1:0] nx;
        int d;
        nx = '0;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
            m_act = '0;
            m_exp = '0;
            m_pos = -1;
            m_pend = 1'b0;
            m_ovr = 1'b0;
        end else begin
            if (m_pos >= 0 && m_act[m_pos] && !start[m_pos] && !cancel[m_pos]) begin
                if (m_cnt[m_pos] == 1) begin
                    m_cnt[m_pos] = 0;
                    m_act[m_pos] = 1'b0;
                    nx[m_pos] = 1'b1;
                end else begin
                    m_cnt[m_pos] = m_cnt[m_pos] - 1;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                d = int'(dur_ms[i*CNT_W +: CNT_W]);
                if (start[i]) begin
                    m_cnt[i] = d;
                    m_act[i] = (d != 0);
                    nx[i] = (d == 0);
                end else if (cancel[i]) begin
                    m_act[i] = 1'b0;
                end
            end
            m_exp = nx;
            if (tick_1ms && m_pend) m_ovr = 1'b1;
            if (m_pos < 0) begin
                if (tick_1ms || m_pend) begin
                    m_pos = 0;
                    m_pend = 1'b0;
                end
            end else if (m_pos == NUM_CH - 1) begin
                m_pos = m_pend ? 0 : -1;
                m_pend = tick_1ms;
            end else begin
                m_pos = m_pos + 1;
                if (tick_1ms) m_pend = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (run) begin
            chk("model_busy", busy, m_act);
            chk("model_expired", expired, m_exp);
            chk("model_sweeping", sweeping, m_pos >= 0);
            chk("model_overrun", overrun, m_ovr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        seen |= expired;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_tick();
        tick_1ms = 1'b1;
        step();
        tick_1ms = 1'b0;
    endtask

    initial begin
        idle(2);
        run = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_expired", expired, 0);
        chk("rst_sweeping", sweeping, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        step();

        dur_ms[0*CNT_W +: CNT_W] = 16'd3;
        start = 4'b0001;
        step();
        start = '0;
        chk("t1_busy_arm", busy[0], 1);
        for (int k = 1; k <= 3; k++) begin
            idle(98);
            pulse_tick();
            chk("t1_exp_t1", expired, 0);
            step();
            chk("t1_exp_t2", expired, (k == 3) ? 1 : 0);
            chk("t1_busy", busy[0], (k == 3) ? 0 : 1);
        end
        idle(10);

        for (int i = 0; i < NUM_CH; i++) dur_ms[i*CNT_W +: CNT_W] = 16'd2;
        start = 4'b1111;
        step();
        start = '0;
        chk("t2_busy_all", busy, 15);
        idle(20);
        pulse_tick();
        idle(20);
        pulse_tick();
        chk("t2_exp_t1", expired, 0);
        for (int i = 0; i < NUM_CH; i++) begin
            step();
            chk("t2_exp_seq", expired, 1 << i);
        end
        step();
        chk("t2_exp_done", expired, 0);
        idle(10);

        dur_ms[1*CNT_W +: CNT_W] = 16'd5;
        start = 4'b0010;
        step();
        start = '0;
        pulse_tick();
        idle(20);
        pulse_tick();
        idle(20);
        cancel = 4'b0010;
        step();
        cancel = '0;
        chk("t3_busy_cancel", busy[1], 0);
        seen = '0;
        repeat (5) begin
            pulse_tick();
            idle(20);
        end
        chk("t3_no_exp1", seen[1], 0);

        dur_ms[2*CNT_W +: CNT_W] = 16'd0;
        start = 4'b0100;
        step();
        start = '0;
        chk("t4_zero_exp", expired, 4);
        chk("t4_zero_busy", busy[2], 0);
        step();
        chk("t4_zero_once", expired, 0);
        dur_ms[2*CNT_W +: CNT_W] = 16'd4;
        start = 4'b0100;
        cancel = 4'b0100;
        step();
        start = '0;
        cancel = '0;
        chk("t4_start_over_cancel", busy[2], 1);
        cancel = 4'b0100;
        step();
        cancel = '0;
        idle(10);

        pulse_tick();
        chk("t5_sweep_t1", sweeping, 1);
        step();
        tick_1ms = 1'b1;
        step();
        step();
        tick_1ms = 1'b0;
        chk("t5_overrun", overrun, 1);
        chk("t5_sweep_t4", sweeping, 1);
        step();
        chk("t5_resweep_t5", sweeping, 1);
        idle(3);
        chk("t5_resweep_t8", sweeping, 1);
        step();
        chk("t5_idle_t9", sweeping, 0);
        idle(50);
        chk("t5_overrun_sticky", overrun, 1);

        dur_ms[3*CNT_W +: CNT_W] = 16'd1;
        start = 4'b1000;
        step();
        start = '0;
        chk("t6_busy", busy, 8);
        pulse_tick();
        idle(3);
        rst = 1'b1;
        step();
        chk("t6_rst_expired", expired, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_sweeping", sweeping, 0);
        chk("t6_rst_overrun", overrun, 0);
        rst = 1'b0;
        seen = '0;
        idle(5);
        chk("t6_no_late_exp", seen, 0);

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ms_timer_scheduler.md
# ms_timer_scheduler

Multi-channel millisecond timeout service driven by the shared 1 ms tick from the clock divider. Up to NUM_CH requesters (beat-interval watchdog, refractory window, asystole timeout, display refresh) each arm a countdown in milliseconds. The block time-multiplexes one decrement unit across all channels on every tick and returns a one-cycle expiry pulse per channel. It sits between the clock divider and the heart-rate/arrhythmia detection FSMs.

## Interface
Parameters:
- NUM_CH, 4: number of timer channels (1..16)
- CNT_W, 16: countdown width in ms (max timeout 2^CNT_W-1 ms)

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- tick_1ms  in  1  one-cycle pulse every 1 ms from the clock divider
- start  in  NUM_CH  per-channel arm/re-arm strobe
- cancel  in  NUM_CH  per-channel disarm strobe
- dur_ms  in  NUM_CH*CNT_W  per-channel duration; channel i uses bits [i*CNT_W +: CNT_W]; sampled only with start[i]
- busy  out  NUM_CH  channel armed and counting
- expired  out  NUM_CH  one-cycle pulse when the channel's timeout elapses
- sweeping  out  1  decrement sweep in progress
- overrun  out  1  sticky; a tick was lost

## Operation
- Per channel, the block keeps count[i] (CNT_W bits) and active[i].
- FSM states:
  - IDLE: on tick_1ms, or on tick_pend set, clear tick_pend, set idx=0 and go to SWEEP.
  - SWEEP: service channel idx, one channel per cycle.
  - Leave SWEEP after idx==NUM_CH-1. Return to IDLE, or restart at idx=0 if tick_pend is set.
- Service of channel idx:
  - If active and count==1: count←0, active←0, expired[idx] pulses.
  - If active and count>1: count←count-1.
  - If inactive: no change.
- start[i]:
  - Loads count[i]←dur_ms[i] and active[i]←1. This restarts an already-armed channel.
  - If dur_ms[i]==0: active stays 0 and expired[i] pulses next cycle.
- cancel[i]: active[i]←0 with no expired pulse.
- Priority on the same channel in the same cycle: start > cancel > sweep service. A start that collides with its channel's sweep slot loads dur_ms unmodified, so that tick is not applied to the new count.
- A tick arriving during SWEEP sets tick_pend.
- A tick arriving while tick_pend is already set sets overrun. overrun clears only on rst.
- Expiry resolution: the first tick after start counts as a full millisecond. Real elapsed time is therefore in (D-1, D] ms plus at most NUM_CH+1 cycles.

## Timing
- Reset values: busy=0, expired=0, sweeping=0, overrun=0; all count=0, active=0, tick_pend=0; FSM in IDLE.
- start[i] at cycle t: busy[i]=1 at t+1.
- cancel[i] at cycle t: busy[i]=0 at t+1.
- tick_1ms at cycle T in IDLE:
  - sweeping=1 from T+1 to T+NUM_CH.
  - Channel i is serviced in cycle T+1+i.
  - expired[i] and the fall of busy[i] are registered at T+2+i.
- expired is a single-cycle pulse per expiry. Several bits may pulse in consecutive cycles but never in the same cycle, except through zero-duration starts.
- With tick spacing ≥ NUM_CH+1 cycles, no tick is lost and overrun never sets. At 50 MHz the spacing is 50 000 cycles.
- rst asserted mid-sweep: all state returns to reset values on the next edge, and no expired pulse is emitted.

## Structure
- Package ms_timer_sched_pkg holds:
  - the FSM state enum (IDLE, SWEEP)
  - localparams for the default NUM_CH/CNT_W
  - an index-width function, clog2(NUM_CH) with a minimum of 1
- Sub-module ms_timer_chan_regs: the count/active register file with the start/cancel/service write priority. It takes one service port (idx, dec_en) and returns a registered expiry strobe.
- The top level holds the FSM, idx counter, tick_pend/overrun logic and the expired decode.

## Test plan
- Arm channel 0 with dur=3, then apply ticks every 100 cycles → busy[0]=1 until expired[0] pulses exactly 2 cycles after the third tick; no other expired bits fire.
- Arm channels 0–3 with dur=2 in the same cycle, then send two ticks → expired[0..3] pulse in 4 consecutive cycles, starting 2 cycles after the second tick.
- Arm channel 1 with dur=5, cancel it after 2 ticks, then send 5 more ticks → busy[1]=0 the cycle after cancel; expired[1] never pulses.
- Apply start[2] (dur=0) → expired[2] pulses next cycle and busy[2] stays 0. Apply start and cancel on channel 2 in the same cycle with dur=4 → busy[2]=1.
- Send a tick in IDLE, a second tick during the sweep, and a third before the sweep ends (NUM_CH=4) → one extra sweep runs back-to-back and overrun=1, sticky until rst.
- Assert rst during a sweep while channel 3 is at count=1 → no expired pulse; all outputs are 0 the next cycle.
